// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//
// Round-robin push arbiter sharing one FIFO write port among NUM_REQ
// producers. One producer at a time is granted a burst of up to BURST_LEN
// pushes. FIFO occupancy is tracked here from the pushes this block makes and
// the pops it observes, so the FIFO is never pushed while full.
//
// Optional feature (compile-time macro):
//   FIFO_ARB_PRIORITY_EN  - requester 0 wins every arbitration in IDLE; a
//                           burst owned by requester 0 leaves rr_ptr as is.
//   undefined (default)   - pure round-robin for all requesters.
//
// Handshake: req[i] acts as valid and holds req_data slice i stable while set;
// ack[i] is the same-cycle "taken" strobe. A word moves only in a cycle where
// ack[i] is high, and a producer may drop req at any time.
//
// Ports:
//   clock       in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   req         in   [NUM_REQ]          per-producer push request
//   req_data    in   [NUM_REQ*DATA_W]   producer i word in [i*DATA_W +: DATA_W]
//   gnt         out  [NUM_REQ]          registered one-hot grant, 0 when idle
//   ack         out  [NUM_REQ]          word of producer i pushed this cycle
//   fifo_push   out  push strobe to the FIFO
//   fifo_data   out  [DATA_W]           granted producer's word
//   fifo_pop    in   consumer pop strobe (observed only)
//   fifo_count  out  [$clog2(FIFO_SIZE+1)] registered occupancy
//   fifo_empty  out  fifo_count == 0
//   state_dbg   out  current FSM state (0 = IDLE, 1 = BURST)

module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 10,
  parameter int FIFO_SIZE = 6,
  parameter int BURST_LEN = 4
) (
  input  logic                              clock,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATA_W-1:0]         req_data,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [NUM_REQ-1:0]                ack,
  output logic                              fifo_push,
  output logic [DATA_W-1:0]                 fifo_data,
  input  logic                              fifo_pop,
  output logic [$clog2(FIFO_SIZE+1)-1:0]    fifo_count,
  output logic                              fifo_empty,
  output logic                              state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FIFO_SIZE+1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [3:0]         beats_q, beats_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   owner_next_rr;
  logic               credit_ok;
  logic               pop_ok;
  logic               end_burst;

  assign credit_ok = (count_q < CNT_W'(FIFO_SIZE));
  assign pop_ok    = fifo_pop && (count_q != '0);

  // Winner search: walk offsets from the highest down so that the smallest
  // offset from rr_q (the first set req scanning upward with wrap) is the
  // last assignment and therefore wins.
  always_comb begin
    int idx;
    idx     = 0;
    sel_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (req[idx]) begin
        sel_idx = IDX_W'(idx);
      end
    end
`ifdef FIFO_ARB_PRIORITY_EN
    if (req[0]) begin
      sel_idx = '0;
    end
`endif
  end

  // Index following the current owner, wrapping for non power-of-2 NUM_REQ.
  assign owner_next_rr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Datapath outputs.
  always_comb begin
    fifo_push = 1'b0;
    fifo_data = '0;
    ack       = '0;
    if (state_q == ST_BURST) begin
      fifo_push = req[owner_q] && credit_ok;
      fifo_data = req_data[owner_q*DATA_W +: DATA_W];
      if (fifo_push) begin
        ack = NUM_REQ'(1) << owner_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    beats_d   = beats_q;
    gnt_d     = gnt_q;
    end_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if ((|req) && credit_ok) begin
          state_d = ST_BURST;
          owner_d = sel_idx;
          gnt_d   = NUM_REQ'(1) << sel_idx;
          beats_d = '0;
        end
      end
      ST_BURST: begin
        if (fifo_push) begin
          beats_d = beats_q + 4'd1;
          if (beats_q == 4'(BURST_LEN - 1)) begin
            end_burst = 1'b1;
          end
        end else if (!req[owner_q]) begin
          end_burst = 1'b1;
        end
        // req high with no credit falls through: a stall holding beats/gnt.
        if (end_burst) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          rr_d    = owner_next_rr;
`ifdef FIFO_ARB_PRIORITY_EN
          if (owner_q == '0) begin
            rr_d = rr_q;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Push requires credit and pop requires a non-zero count, so this sum can
  // neither exceed FIFO_SIZE nor underflow.
  assign count_d = count_q + CNT_W'(fifo_push) - CNT_W'(pop_ok);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beats_q <= '0;
      gnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beats_q <= beats_d;
      gnt_q   <= gnt_d;
      count_q <= count_d;
    end
  end

  assign gnt        = gnt_q;
  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign state_dbg  = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter (default parameters).
// Producers are modelled as word counters that advance on ack; a cycle-level
// model of the arbitration rules runs on every falling edge.

module tb_fifo_push_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 10;
  localparam int FS   = 6;
  localparam int BL   = 4;
  localparam int CW   = $clog2(FS+1);

  // ---------------- clock / reset ----------------
  logic          clock;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] gnt;
  logic [NR-1:0] ack;
  logic          fifo_push;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          state_dbg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  fifo_push_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .FIFO_SIZE(FS), .BURST_LEN(BL)
  ) dut (
    .clock(clock), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .ack(ack), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .fifo_count(fifo_count), .fifo_empty(fifo_empty),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- producer model / driver tasks ----------------
  int            words_left [NR];
  int            seq        [NR];
  logic [NR-1:0] ack_seen;

  function automatic logic [DW-1:0] word_of(input int i);
    return DW'(i * 100 + seq[i]);
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < NR; i++) begin
      req[i] = (words_left[i] > 0);
      req_data[i*DW +: DW] = word_of(i);
    end
  endtask

  // Advance one clock; producers whose word was acked move to the next word.
  task automatic tick();
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (ack_seen[i]) begin
        words_left[i] = words_left[i] - 1;
        seq[i] = seq[i] + 1;
      end
    end
    apply_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_pop = 1'b0;
    for (int i = 0; i < NR; i++) words_left[i] = 0;
    apply_inputs();
    @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (gnt !== '0 && n < 50) begin
      tick();
      n++;
    end
    check("wait_idle_bound", {31'd0, gnt === '0}, 32'd1);
  endtask

  // ---------------- reference model + scoreboard ----------------
  int            m_owner;   // -1 when idle
  int            m_rr;
  int            m_beats;
  int            m_count;
  logic [DW-1:0] exp_q [$];

  initial begin
    m_owner = -1; m_rr = 0; m_beats = 0; m_count = 0;
    ack_seen = '0;
    forever begin
      @(negedge clock);
      if (rst) begin
        check("rst_gnt",   {28'd0, gnt}, 32'd0);
        check("rst_ack",   {28'd0, ack}, 32'd0);
        check("rst_push",  {31'd0, fifo_push}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_empty", {31'd0, fifo_empty}, 32'd1);
        m_owner = -1; m_rr = 0; m_beats = 0; m_count = 0;
        exp_q.delete();
        ack_seen = '0;
      end else begin
        logic [NR-1:0] e_gnt;
        logic          credit;
        logic          e_push;
        logic          pop_ok;
        logic          done;
        int            w;
        e_gnt  = (m_owner >= 0) ? NR'(1) << m_owner : '0;
        credit = (m_count < FS);
        e_push = (m_owner >= 0) && req[m_owner] && credit;
        check("gnt",   {28'd0, gnt}, {28'd0, e_gnt});
        check("ack",   {28'd0, ack}, e_push ? {28'd0, e_gnt} : 32'd0);
        check("push",  {31'd0, fifo_push}, {31'd0, e_push});
        check("count", {29'd0, fifo_count}, 32'(m_count));
        check("empty", {31'd0, fifo_empty}, {31'd0, m_count == 0});
        check("state", {31'd0, state_dbg}, {31'd0, m_owner >= 0});
        if (e_push) exp_q.push_back(word_of(m_owner));
        if (fifo_push === 1'b1 && exp_q.size() > 0) begin
          check("data", {22'd0, fifo_data}, {22'd0, exp_q.pop_front()});
        end
        exp_q.delete();
        ack_seen = ack;

        pop_ok = fifo_pop && (m_count > 0);
        if (m_owner < 0) begin
          if (req != '0 && credit) begin
            w = -1;
`ifdef FIFO_ARB_PRIORITY_EN
            if (req[0]) w = 0;
`endif
            for (int k = 0; k < NR; k++) begin
              if (w < 0 && req[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            end
            m_owner = w;
            m_beats = 0;
          end
        end else begin
          done = 1'b0;
          if (e_push) begin
            m_beats++;
            if (m_beats == BL) done = 1'b1;
          end else if (!req[m_owner]) begin
            done = 1'b1;
          end
          if (done) begin
`ifdef FIFO_ARB_PRIORITY_EN
            if (m_owner != 0) m_rr = (m_owner + 1) % NR;
`else
            m_rr = (m_owner + 1) % NR;
`endif
            m_owner = -1;
          end
        end
        m_count = m_count + int'(e_push) - int'(pop_ok);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int order_q [$];
    int max_cnt;
    int n;
    logic [NR-1:0] prev_gnt;

    rst = 1'b1;
    fifo_pop = 1'b0;
    for (int i = 0; i < NR; i++) begin
      words_left[i] = 0;
      seq[i] = 0;
    end
    apply_inputs();
    repeat (2) @(posedge clock);
    #1;
    check("lit_reset_empty", {31'd0, fifo_empty}, 32'd1);
    rst = 1'b0;
    tick();

    // Single producer, 6 words: 4-push burst, one bubble, 2-push burst.
    words_left[1] = 6;
    apply_inputs();
    tick();
    check("lit_t1_gnt", {28'd0, gnt}, 32'b0010);
    check("lit_t1_ack", {28'd0, ack}, 32'b0010);
    repeat (3) tick();
    check("lit_t1_ack4", {28'd0, ack}, 32'b0010);
    tick();
    check("lit_t1_bubble", {28'd0, gnt}, 32'd0);
    tick();
    check("lit_t1_regrant", {28'd0, gnt}, 32'b0010);
    tick();
    tick();
    check("lit_t1_count6", {29'd0, fifo_count}, 32'd6);
    check("lit_t1_nopush", {31'd0, fifo_push}, 32'd0);
    tick();
    check("lit_t1_idle", {28'd0, gnt}, 32'd0);

    // All four requesting, consumer pops every cycle.
    do_reset();
    for (int i = 0; i < NR; i++) words_left[i] = 8;
    apply_inputs();
    fifo_pop = 1'b1;
    max_cnt = 0;
    prev_gnt = '0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (prev_gnt == '0 && gnt != '0) begin
        for (int i = 0; i < NR; i++) if (gnt[i]) order_q.push_back(i);
      end
      prev_gnt = gnt;
    end
    check("lit_rr_count_le1", {31'd0, max_cnt <= 1}, 32'd1);
    check("lit_rr_ngrants", {31'd0, order_q.size() >= 5}, 32'd1);
    if (order_q.size() >= 5) begin
      check("lit_rr_g0", 32'(order_q[0]), 32'd0);
      check("lit_rr_g1", 32'(order_q[1]), 32'd1);
      check("lit_rr_g2", 32'(order_q[2]), 32'd2);
      check("lit_rr_g3", 32'(order_q[3]), 32'd3);
      check("lit_rr_g4", 32'(order_q[4]), 32'd0);
    end
    for (int i = 0; i < NR; i++) words_left[i] = 0;
    apply_inputs();
    wait_idle();
    repeat (3) tick();
    fifo_pop = 1'b0;

    // Credit stall at count 5 -> 6, then one pop frees a slot.
    do_reset();
    words_left[0] = 5;
    apply_inputs();
    n = 0;
    while (!(fifo_count == CW'(5) && gnt == '0) && n < 40) begin
      tick();
      n++;
    end
    check("lit_st_fill5", {29'd0, fifo_count}, 32'd5);
    words_left[2] = 3;
    apply_inputs();
    tick();
    check("lit_st_gnt", {28'd0, gnt}, 32'b0100);
    check("lit_st_push1", {31'd0, fifo_push}, 32'd1);
    tick();
    check("lit_st_count6", {29'd0, fifo_count}, 32'd6);
    check("lit_st_stall", {31'd0, fifo_push}, 32'd0);
    check("lit_st_hold", {28'd0, gnt}, 32'b0100);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("lit_st_resume_cnt", {29'd0, fifo_count}, 32'd5);
    check("lit_st_resume", {31'd0, fifo_push}, 32'd1);

    // Simultaneous push and pop at count 3; pop while empty.
    do_reset();
    words_left[3] = 3;
    apply_inputs();
    n = 0;
    while (!(fifo_count == CW'(3) && gnt == '0) && n < 40) begin
      tick();
      n++;
    end
    check("lit_pp_fill3", {29'd0, fifo_count}, 32'd3);
    words_left[1] = 1;
    apply_inputs();
    tick();
    check("lit_pp_push", {31'd0, fifo_push}, 32'd1);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("lit_pp_count3", {29'd0, fifo_count}, 32'd3);
    wait_idle();
    do_reset();
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("lit_pop_empty_cnt", {29'd0, fifo_count}, 32'd0);
    check("lit_pop_empty", {31'd0, fifo_empty}, 32'd1);

    // Reset mid-burst at beats == 2, after rr has moved to 2.
    do_reset();
    words_left[1] = 1;
    apply_inputs();
    tick();
    wait_idle();
    words_left[2] = 4;
    apply_inputs();
    repeat (3) tick();
    check("lit_mr_burst", {28'd0, gnt}, 32'b0100);
    rst = 1'b1;
    #1;
    check("lit_mr_gnt", {28'd0, gnt}, 32'd0);
    check("lit_mr_count", {29'd0, fifo_count}, 32'd0);
    check("lit_mr_push", {31'd0, fifo_push}, 32'd0);
    words_left[2] = 0;
    words_left[1] = 1;
    words_left[3] = 1;
    apply_inputs();
    tick();
    rst = 1'b0;
    tick();
    check("lit_mr_from0", {28'd0, gnt}, 32'b0010);
    wait_idle();
    wait_idle();

    // rr_ptr = 2 with req = 0101.
    do_reset();
    words_left[1] = 1;
    apply_inputs();
    tick();
    wait_idle();
    words_left[0] = 1;
    words_left[2] = 1;
    apply_inputs();
    tick();
`ifdef FIFO_ARB_PRIORITY_EN
    check("lit_prio_gnt", {28'd0, gnt}, 32'b0001);
`else
    check("lit_prio_gnt", {28'd0, gnt}, 32'b0100);
`endif
    wait_idle();
    wait_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin push arbiter that shares one `fifo` instance among `NUM_REQ` producers. Grants one producer at a time a burst of up to `BURST_LEN` pushes, drives the FIFO's push/data inputs, and tracks FIFO occupancy from observed pushes and pops. It never pushes into a full FIFO. Sits between the producer blocks and the shared FIFO write port; the consumer pops the FIFO directly, and the arbiter observes that pop.

## Interface
- `NUM_REQ`, 4, number of producers (2..8)
- `DATA_W`, 10, FIFO word width
- `FIFO_SIZE`, 6, FIFO depth in words; sets the credit limit
- `BURST_LEN`, 4, maximum pushes per grant (1..15)

- `clock`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  NUM_REQ  per-producer push request; the producer holds it and its data while it has words to send
- `req_data`  in  NUM_REQ*DATA_W  producer i's word in bits [i*DATA_W +: DATA_W]
- `gnt`  out  NUM_REQ  registered one-hot grant; all zero when idle
- `ack`  out  NUM_REQ  combinational; `ack[i]`=1 means producer i's word is pushed this cycle
- `fifo_push`  out  1  combinational push strobe to the FIFO
- `fifo_data`  out  DATA_W  combinational; the granted producer's word
- `fifo_pop`  in  1  consumer pop strobe, observed only
- `fifo_count`  out  $clog2(FIFO_SIZE+1)  registered occupancy
- `fifo_empty`  out  1  `fifo_count`==0

## Operation
- States: IDLE and BURST. Registers: `owner` (index), `rr_ptr` (index), `beats` (4 bits), `fifo_count`.
- credit_ok = `fifo_count` < FIFO_SIZE.
- IDLE: if any `req` bit is set and credit_ok, select the first set `req[i]` scanning from `rr_ptr` upward with wrap. Then set `owner`=i, `gnt`=one-hot(i), `beats`=0, and go to BURST. Otherwise stay in IDLE with `gnt`=0.
- BURST: `fifo_push` = `req[owner]` && credit_ok; `fifo_data` = slice `owner` of `req_data`; `ack[owner]` = `fifo_push`. All other `ack` bits are 0.
- Each push increments `beats`.
- Leave BURST for IDLE, clearing `gnt` and setting `rr_ptr`=(`owner`+1) mod NUM_REQ, when:
  - a push occurs with `beats`==BURST_LEN-1, or
  - `req[owner]` is low.
- credit_ok low with `req[owner]` high is a stall: stay in BURST, no push, hold `beats` and `gnt`.
- Occupancy: pop_ok = `fifo_pop` && `fifo_count`>0. The next count is `fifo_count` + `fifo_push` - pop_ok.
  - A push and a pop in the same cycle leave the count unchanged.
  - A pop while empty is ignored.
  - The count never exceeds FIFO_SIZE.
- The pop side has no effect on arbitration other than freeing credit.
- `rr_ptr` and index arithmetic wrap modulo NUM_REQ; NUM_REQ need not be a power of 2.

## Timing
- Reset values:
  - state IDLE
  - `gnt`=0, `owner`=0, `rr_ptr`=0, `beats`=0, `fifo_count`=0
  - therefore `ack`=0, `fifo_push`=0, `fifo_empty`=1
- Request-to-grant latency is 1 cycle: `req` is sampled in IDLE and `gnt` is asserted on the next edge. The first push happens in that first BURST cycle if credit_ok.
- Back-to-back bursts always have exactly one IDLE bubble cycle.
- A producer may drop `req` at any time. Its word is taken only in a cycle with `ack` high.
- Reset asserted mid-burst clears all state immediately (asynchronous). A push in the same cycle does not count. `fifo_count` restarts at 0, so the FIFO must be reset together with this block.

## Configuration
- `FIFO_ARB_PRIORITY_EN` defined: in IDLE, `req[0]` wins over all others regardless of `rr_ptr`. Other indices stay round-robin. `rr_ptr` is not updated when the ending burst belonged to requester 0.
- `FIFO_ARB_PRIORITY_EN` undefined: pure round-robin for all requesters.

## Test plan
- Single producer, `req[1]`=1 held with 6 words, FIFO empty, no pops:
  - `gnt`=0010 one cycle after `req`
  - 4 pushes (`ack[1]`=1 on 4 consecutive cycles), then one IDLE cycle, then a regrant with 2 more pushes
  - `fifo_count`=6, no further `fifo_push`
- All 4 `req` high continuously, consumer pops every cycle: grant order 0,1,2,3,0. Each burst is 4 pushes. `fifo_count` stays ≤1.
- Credit stall: `fifo_count`=5, `req[2]` held:
  - one push, then `fifo_count`=6 and `fifo_push`=0 with `gnt[2]` still high
  - one `fifo_pop` resumes the pushes in the following cycle
- Simultaneous push and pop at `fifo_count`=3: count stays 3. A pop at count 0 leaves the count at 0.
- Assert `rst` mid-burst (at `beats`=2): `gnt`=0, `fifo_count`=0, `fifo_push`=0 immediately. Next arbitration starts from index 0.
- With `FIFO_ARB_PRIORITY_EN`: `rr_ptr`=2, `req`=0101 → `gnt`=0001. Without it, the same stimulus gives `gnt`=0100.
